// File: rtl/cdc_word_receiver.sv
// ---------------------------------------------------------------------------
// cdc_word_receiver
// Receiving-domain end of a 2-phase (toggle) req/ack word-transfer CDC link.
// A change on the already-synchronized req toggle starts a transfer. After a
// settle delay the sender-held data bus is sampled into a 1-entry output
// buffer (valid/ready handshake) and the ack toggle is flipped back to the
// sender. While the buffer is occupied and not draining, the ack is withheld.
//
// Ports
//   receiving_clock    in   receiving-domain clock
//   receiving_reset_n  in   asynchronous active-low reset
//   req_sync           in   synchronized req toggle from the sender
//   data_in            in   sender-held word, quasi-static while req != ack
//   ack_toggle         out  registered ack toggle back to the sender
//   data_out           out  buffered word
//   valid_out          out  data_out holds an unconsumed word
//   ready_in           in   downstream accepts when valid_out & ready_in
//   busy               out  a request has been seen but not yet captured
// ---------------------------------------------------------------------------
module cdc_word_receiver #(
   parameter int unsigned WORD_WIDTH    = 8,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic                  receiving_clock,
   input  logic                  receiving_reset_n,
   input  logic                  req_sync,
   input  logic [WORD_WIDTH-1:0] data_in,
   output logic                  ack_toggle,
   output logic [WORD_WIDTH-1:0] data_out,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic                  busy
);

   localparam int unsigned CNT_W = $clog2(16);

   // The IDLE cycle that detects the edge is the first of the settle window,
   // so SETTLE is entered with one count fewer. This gives capture at the end
   // of cycle t+SETTLE_CYCLES for an edge seen in cycle t.
   localparam logic [CNT_W-1:0] SETTLE_LOAD =
      (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_PENDING
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  req_seen_q, req_seen_d;
   logic                  ack_q, ack_d;
   logic [WORD_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;

   logic new_req;
   logic buf_free;
   logic settle_done;
   logic capture;

   assign new_req  = req_sync ^ req_seen_q;
   // Draining and capturing on the same edge is allowed, so a buffer that is
   // being accepted this cycle counts as free.
   assign buf_free = ~valid_q | ready_in;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_seen_d  = req_seen_q;
      ack_d       = ack_q;
      data_d      = data_q;
      valid_d     = valid_q;
      settle_done = 1'b0;
      capture     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (new_req) begin
               if (SETTLE_CYCLES == 0) begin
                  settle_done = 1'b1;
               end else begin
                  state_d = ST_SETTLE;
                  cnt_d   = SETTLE_LOAD;
               end
            end
         end
         ST_SETTLE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               settle_done = 1'b1;
            end
         end
         ST_PENDING: begin
            if (buf_free) begin
               capture = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (settle_done) begin
         if (buf_free) begin
            capture = 1'b1;
         end else begin
            state_d = ST_PENDING;
         end
      end

      if (valid_q & ready_in) begin
         valid_d = 1'b0;
      end

      if (capture) begin
         data_d     = data_in;
         valid_d    = 1'b1;
         ack_d      = ~ack_q;
         req_seen_d = req_sync;
         state_d    = ST_IDLE;
      end
   end

   always_ff @(posedge receiving_clock or negedge receiving_reset_n) begin
      if (!receiving_reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         req_seen_q <= 1'b0;
         ack_q      <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_seen_q <= req_seen_d;
         ack_q      <= ack_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
      end
   end

   assign ack_toggle = ack_q;
   assign data_out   = data_q;
   assign valid_out  = valid_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cdc_word_receiver.sv
// ---------------------------------------------------------------------------
// tb_cdc_word_receiver
// Three receivers with different settle delays (1, 0, 3) share one clock and
// reset. Single-word transfers come from a table; multi-cycle corner cases
// (backpressure, reset mid-settle, settle timing) are hand-written; a random
// stream is checked against a queue of words the sender model has issued.
// ---------------------------------------------------------------------------
module tb_cdc_word_receiver;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic r1, a1, v1, rdy1, b1;
   logic [7:0] d1, q1;
   logic r0, a0, v0, rdy0, b0;
   logic [7:0] d0, q0;
   logic r3, a3, v3, rdy3, b3;
   logic [7:0] d3, q3;

   cdc_word_receiver #(.WORD_WIDTH(8), .SETTLE_CYCLES(1)) u_s1 (
      .receiving_clock(clk), .receiving_reset_n(rst_n), .req_sync(r1),
      .data_in(d1), .ack_toggle(a1), .data_out(q1), .valid_out(v1),
      .ready_in(rdy1), .busy(b1));

   cdc_word_receiver #(.WORD_WIDTH(8), .SETTLE_CYCLES(0)) u_s0 (
      .receiving_clock(clk), .receiving_reset_n(rst_n), .req_sync(r0),
      .data_in(d0), .ack_toggle(a0), .data_out(q0), .valid_out(v0),
      .ready_in(rdy0), .busy(b0));

   cdc_word_receiver #(.WORD_WIDTH(8), .SETTLE_CYCLES(3)) u_s3 (
      .receiving_clock(clk), .receiving_reset_n(rst_n), .req_sync(r3),
      .data_in(d3), .ack_toggle(a3), .data_out(q3), .valid_out(v3),
      .ready_in(rdy3), .busy(b3));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   typedef struct {
      logic [7:0] data;
      int         idle;
      int         exp_lat;
      logic [7:0] exp_data;
   } vec_t;

   vec_t       vec[5];
   logic       exp_a1;
   int         lat;
   logic [7:0] exp_q[$];
   logic [7:0] hold_q;
   logic [7:0] want;
   logic       acc, stall, prev_a;
   int         sent, got, acks, cycles;

   initial begin
      // {data, idle cycles before request, expected latency, expected word}
      vec[0] = '{8'hA5, 3, 2, 8'hA5};
      vec[1] = '{8'h00, 0, 2, 8'h00};
      vec[2] = '{8'hFF, 1, 2, 8'hFF};
      vec[3] = '{8'h5A, 2, 2, 8'h5A};
      vec[4] = '{8'h81, 0, 2, 8'h81};

      rst_n = 1'b0;
      r1 = 0; d1 = '0; rdy1 = 1;
      r0 = 0; d0 = '0; rdy0 = 1;
      r3 = 0; d3 = '0; rdy3 = 1;
      step(2);
      chk("rst_valid", v1, 0);
      chk("rst_data", q1, 0);
      chk("rst_ack", a1, 0);
      chk("rst_busy", b1, 0);
      rst_n = 1'b1;
      step(2);
      chk("idle_no_capture", v1, 0);
      exp_a1 = 1'b0;

      // Single-word transfers, buffer always free
      for (int i = 0; i < 5; i++) begin
         step(vec[i].idle);
         d1 = vec[i].data;
         r1 = ~r1;
         lat = 0;
         while (!v1 && lat < 10) begin
            step();
            lat++;
            if (lat == 1) chk("busy_settle", b1, 1);
         end
         exp_a1 = ~exp_a1;
         chk("latency", lat, vec[i].exp_lat);
         chk("word", q1, vec[i].exp_data);
         chk("ack", a1, exp_a1);
         chk("busy_after", b1, 0);
         step();
         chk("drain", v1, 0);
         chk("hold_after_drain", q1, vec[i].exp_data);
      end

      // Zero settle delay: edge seen at t, visible at t+1
      d0 = 8'h3C;
      r0 = 1;
      step();
      chk("s0_valid", v0, 1);
      chk("s0_data", q0, 8'h3C);
      chk("s0_ack", a0, 1);

      // Settle honoured with 3-cycle delay: data changes at t+2
      d3 = 8'h00;
      r3 = 1;
      step(2);
      d3 = 8'hFF;
      step();
      chk("s3_not_early", v3, 0);
      step();
      chk("s3_valid", v3, 1);
      chk("s3_data", q3, 8'hFF);
      chk("s3_ack", a3, 1);

      // Backpressure: second word waits in PENDING with ack withheld
      rdy1 = 0;
      d1 = 8'h11;
      r1 = ~r1;
      step(2);
      exp_a1 = ~exp_a1;
      chk("bp_first_valid", v1, 1);
      chk("bp_first_data", q1, 8'h11);
      chk("bp_first_ack", a1, exp_a1);
      d1 = 8'h22;
      r1 = ~r1;
      step(4);
      chk("bp_pending_busy", b1, 1);
      chk("bp_pending_valid", v1, 1);
      chk("bp_pending_data", q1, 8'h11);
      chk("bp_ack_withheld", a1, exp_a1);
      rdy1 = 1;
      step();
      exp_a1 = ~exp_a1;
      chk("bp_swap_valid", v1, 1);
      chk("bp_swap_data", q1, 8'h22);
      chk("bp_swap_ack", a1, exp_a1);
      chk("bp_swap_busy", b1, 0);
      step();
      chk("bp_drain", v1, 0);

      // Reset mid-settle with a word already buffered
      rdy1 = 0;
      d1 = 8'hA5;
      r1 = ~r1;
      step(2);
      d1 = 8'h5A;
      r1 = ~r1;
      step();
      chk("pre_rst_busy", b1, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", v1, 0);
      chk("mid_rst_data", q1, 0);
      chk("mid_rst_ack", a1, 0);
      chk("mid_rst_busy", b1, 0);
      r1 = 0; r0 = 0; r3 = 0;
      step();
      rst_n = 1'b1;
      step(5);
      chk("post_rst_valid", v1, 0);
      chk("post_rst_ack", a1, 0);
      chk("post_rst_busy", b1, 0);

      // Random stream of 16 words with random ready
      sent = 0; got = 0; acks = 0; cycles = 0;
      prev_a = a1;
      while (got < 16 && cycles < 3000) begin
         rdy1   = 1'($urandom_range(0, 1));
         acc    = v1 & rdy1;
         stall  = v1 & ~rdy1;
         hold_q = q1;
         step();
         cycles++;
         if (acc) begin
            if (exp_q.size() == 0) begin
               chk("stream_extra_word", 1, 0);
            end else begin
               want = exp_q.pop_front();
               chk("stream_word", hold_q, want);
            end
            got++;
         end
         if (stall) begin
            chk("stall_valid", v1, 1);
            chk("stall_data", q1, hold_q);
         end
         if (a1 != prev_a) begin
            acks++;
            prev_a = a1;
         end
         if (r1 == a1 && sent < 16 && $urandom_range(0, 3) != 0) begin
            d1 = sent[7:0];
            r1 = ~r1;
            exp_q.push_back(sent[7:0]);
            sent++;
         end
      end
      chk("stream_received", got, 16);
      chk("stream_acks", acks, 16);
      chk("stream_sent", sent, 16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
